// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between mem_stage and data memory.
// The master drives the request side; the slave answers with ack/rdata.
interface mem_stage_if #(
    parameter int DATA_W = 32
);
    logic              dmem_req;
    logic              dmem_we;
    logic [DATA_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic              dmem_ack;
    logic [DATA_W-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage: loads/stores over a req/ack bus, registered WB bundle.
// Define MEM_TIMEOUT_EN to abort WAIT after TIMEOUT_CYCLES cycles without ack.
module mem_stage #(
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] alu_in,
    input  logic [DATA_W-1:0] store_data_in,
    input  logic [4:0]        dst_in,
    input  logic              reg_write_in,
    input  logic              mem_read_in,
    input  logic              mem_write_in,
    output logic              stall_out,
    mem_stage_if.master       dmem,
    output logic              wb_valid,
    output logic [DATA_W-1:0] wb_data,
    output logic [4:0]        wb_dst,
    output logic              wb_reg_write,
    output logic              mem_error
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

    logic [0:0]        state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [4:0]        dst_q, dst_d;
    logic              rw_q, rw_d;
    logic              wb_valid_q, wb_valid_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic [4:0]        wb_dst_q, wb_dst_d;
    logic              wb_rw_q, wb_rw_d;
    logic              is_mem;
    logic              timeout_hit;

    assign is_mem = valid_in & (mem_read_in | mem_write_in);

    // Upstream may advance on the edge that completes or aborts the access
    assign stall_out = reset &
        (((state_q == IDLE) & is_mem) |
         ((state_q == WAIT) & ~dmem.dmem_ack & ~timeout_hit));

    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;
    assign wb_valid        = wb_valid_q;
    assign wb_data         = wb_data_q;
    assign wb_dst          = wb_dst_q;
    assign wb_reg_write    = wb_rw_q;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W =
        ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mem_error_q, mem_error_d;

    assign timeout_hit = (state_q == WAIT) &&
                         (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign mem_error   = mem_error_q;

    always_comb begin
        cnt_d       = cnt_q;
        mem_error_d = timeout_hit & ~dmem.dmem_ack;
        if (state_q == IDLE)
            cnt_d = '0;
        else if (!dmem.dmem_ack)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q       <= '0;
            mem_error_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            mem_error_q <= mem_error_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign mem_error   = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        dst_d      = dst_q;
        rw_d       = rw_q;
        wb_valid_d = 1'b0;
        wb_data_d  = wb_data_q;
        wb_dst_d   = wb_dst_q;
        wb_rw_d    = wb_rw_q;
        unique case (state_q)
            IDLE: begin
                if (is_mem) begin
                    state_d = WAIT;
                    req_d   = 1'b1;
                    we_d    = mem_write_in;
                    addr_d  = alu_in;
                    wdata_d = store_data_in;
                    dst_d   = dst_in;
                    rw_d    = reg_write_in;
                    wb_rw_d = 1'b0;
                end else if (valid_in) begin
                    wb_valid_d = 1'b1;
                    wb_data_d  = alu_in;
                    wb_dst_d   = dst_in;
                    wb_rw_d    = reg_write_in;
                end else begin
                    wb_rw_d = 1'b0;
                end
            end
            WAIT: begin
                if (dmem.dmem_ack) begin
                    state_d    = IDLE;
                    req_d      = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_dst_d   = dst_q;
                    wb_data_d  = we_q ? addr_q : dmem.dmem_rdata;
                    wb_rw_d    = ~we_q & rw_q;
                end else if (timeout_hit) begin
                    state_d    = IDLE;
                    req_d      = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_dst_d   = dst_q;
                    wb_data_d  = addr_q;
                    wb_rw_d    = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            dst_q      <= '0;
            rw_q       <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            wb_dst_q   <= '0;
            wb_rw_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            dst_q      <= dst_d;
            rw_q       <= rw_d;
            wb_valid_q <= wb_valid_d;
            wb_data_q  <= wb_data_d;
            wb_dst_q   <= wb_dst_d;
            wb_rw_q    <= wb_rw_d;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed plan items plus random traffic
// checked against a per-instruction transaction model.
module tb_mem_stage;
    localparam int TO = 4;

    logic        clock;
    logic        reset;
    logic        valid_in;
    logic [31:0] alu_in;
    logic [31:0] store_data_in;
    logic [4:0]  dst_in;
    logic        reg_write_in;
    logic        mem_read_in;
    logic        mem_write_in;
    logic        stall_out;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [4:0]  wb_dst;
    logic        wb_reg_write;
    logic        mem_error;

    int total = 0;
    int bad   = 0;

    logic        exp_v, exp_rw, exp_err, exp_chkd;
    logic [31:0] exp_data;
    logic [4:0]  exp_dst;

    mem_stage_if #(.DATA_W(32)) dmem_if ();

    mem_stage #(.DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
        .clock        (clock),
        .reset        (reset),
        .valid_in     (valid_in),
        .alu_in       (alu_in),
        .store_data_in(store_data_in),
        .dst_in       (dst_in),
        .reg_write_in (reg_write_in),
        .mem_read_in  (mem_read_in),
        .mem_write_in (mem_write_in),
        .stall_out    (stall_out),
        .dmem         (dmem_if),
        .wb_valid     (wb_valid),
        .wb_data      (wb_data),
        .wb_dst       (wb_dst),
        .wb_reg_write (wb_reg_write),
        .mem_error    (mem_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_none();
        exp_v = 1'b0; exp_rw = 1'b0; exp_err = 1'b0; exp_chkd = 1'b0;
        exp_data = '0; exp_dst = '0;
    endtask

    task automatic check_wb();
        chk("wb_valid", wb_valid, exp_v);
        chk("wb_reg_write", wb_reg_write, exp_rw);
        chk("mem_error", mem_error, exp_err);
        if (exp_v) chk("wb_dst", wb_dst, exp_dst);
        if (exp_chkd) chk("wb_data", wb_data, exp_data);
    endtask

    // lat = WAIT cycle (1-based) carrying the ack; 0 = never ack (timeout)
    task automatic run_instr(input logic v, input logic [31:0] alu,
                             input logic [31:0] sd, input logic [4:0] dst,
                             input logic rw, input logic rd, input logic wr,
                             input int lat, input logic [31:0] rdata);
        logic mem;
        int   n;
        mem = v & (rd | wr);
        n = mem ? ((lat == 0) ? TO : lat) : 0;
        valid_in = v; alu_in = alu; store_data_in = sd;
        dst_in = dst; reg_write_in = rw;
        mem_read_in = rd; mem_write_in = wr;
        for (int c = 0; c <= n; c++) begin
            if (c == 0) dmem_if.dmem_ack = 1'($urandom_range(0, 1));
            else dmem_if.dmem_ack = (lat != 0) && (c == lat);
            dmem_if.dmem_rdata = (mem && c == lat && lat != 0) ?
                                 rdata : $urandom;
            @(negedge clock);
            if (c == 0) begin
                check_wb();
                chk("req_idle", dmem_if.dmem_req, 1'b0);
            end else begin
                chk("wb_valid_wait", wb_valid, 1'b0);
                chk("mem_error_wait", mem_error, 1'b0);
                chk("req_wait", dmem_if.dmem_req, 1'b1);
                chk("addr_wait", dmem_if.dmem_addr, alu);
                chk("we_wait", dmem_if.dmem_we, wr);
                if (wr) chk("wdata_wait", dmem_if.dmem_wdata, sd);
            end
            chk("stall", stall_out, mem && (c < n));
            @(posedge clock);
            #1;
        end
        dmem_if.dmem_ack = 1'b0;
        if (!v) begin
            set_none();
        end else if (!mem) begin
            exp_v = 1'b1; exp_data = alu; exp_dst = dst;
            exp_rw = rw; exp_err = 1'b0; exp_chkd = 1'b1;
        end else if (lat == 0) begin
            exp_v = 1'b1; exp_dst = dst; exp_rw = 1'b0;
            exp_err = 1'b1; exp_chkd = 1'b0;
        end else begin
            exp_v = 1'b1; exp_dst = dst; exp_err = 1'b0; exp_chkd = 1'b1;
            exp_data = wr ? alu : rdata;
            exp_rw = wr ? 1'b0 : rw;
        end
    endtask

    initial begin
        reset = 1'b0;
        valid_in = 0; alu_in = 0; store_data_in = 0; dst_in = 0;
        reg_write_in = 0; mem_read_in = 0; mem_write_in = 0;
        dmem_if.dmem_ack = 0; dmem_if.dmem_rdata = 0;
        set_none();
        #1;
        chk("rst_req", dmem_if.dmem_req, 1'b0);
        chk("rst_wb_valid", wb_valid, 1'b0);
        chk("rst_stall", stall_out, 1'b0);
        chk("rst_mem_error", mem_error, 1'b0);
        @(posedge clock); #1;
        reset = 1'b1;

        // Reset in the middle of a pending load
        valid_in = 1; mem_read_in = 1; alu_in = 32'h40; dst_in = 5'd9;
        reg_write_in = 1;
        @(posedge clock); #1;
        @(posedge clock); #2;
        chk("pre_rst_req", dmem_if.dmem_req, 1'b1);
        reset = 1'b0;
        #1;
        chk("async_rst_req", dmem_if.dmem_req, 1'b0);
        chk("async_rst_wb_valid", wb_valid, 1'b0);
        chk("async_rst_stall", stall_out, 1'b0);
        valid_in = 0; mem_read_in = 0;
        @(posedge clock); #1;
        reset = 1'b1;
        set_none();
        run_instr(1, 32'h10, 0, 5'd3, 1, 0, 0, 1, 0);

        // Back-to-back ALU ops
        run_instr(1, 32'd1, 0, 5'd1, 1, 0, 0, 1, 0);
        run_instr(1, 32'd2, 0, 5'd2, 1, 0, 0, 1, 0);
        run_instr(1, 32'd3, 0, 5'd4, 0, 0, 0, 1, 0);

        // Load with slow ack, store with immediate ack, spurious ack
        run_instr(1, 32'h100, 32'h0, 5'd7, 1, 1, 0, 4, 32'hDEADBEEF);
        run_instr(1, 32'h20, 32'h55, 5'd8, 1, 0, 1, 1, 0);
        run_instr(1, 32'h77, 0, 5'd11, 1, 0, 0, 1, 0);
        run_instr(1, 32'h78, 0, 5'd12, 1, 0, 0, 1, 0);

        // Read+write together behaves as a store
        run_instr(1, 32'h30, 32'hA5A5, 5'd13, 1, 1, 1, 2, 32'h1234);

        // Bubble carrying a stale mem_read bit
        run_instr(0, 32'h44, 0, 5'd14, 1, 1, 0, 1, 0);
        run_instr(0, 0, 0, 0, 0, 0, 0, 1, 0);

`ifdef MEM_TIMEOUT_EN
        run_instr(1, 32'h200, 0, 5'd15, 1, 1, 0, 0, 0);
        run_instr(0, 0, 0, 0, 0, 0, 0, 1, 0);
        run_instr(1, 32'h204, 0, 5'd16, 1, 1, 0, TO, 32'hCAFEF00D);
`endif

        for (int i = 0; i < 60; i++) begin
            logic [1:0] kind;
            kind = 2'($urandom_range(0, 3));
            run_instr(kind != 0, $urandom, $urandom,
                      5'($urandom), 1'($urandom),
                      kind[1], (kind == 3) ? 1'($urandom) : 1'b0,
                      $urandom_range(1, 4), $urandom);
        end
        run_instr(0, 0, 0, 0, 0, 0, 0, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage directly downstream of the EX/MEM pipeline register.
- Consumes the registered ALU result, destination register, and control bits, and performs loads and stores on the data memory using a req/ack handshake.
- Stalls upstream while an access is outstanding.
- Presents a registered writeback bundle (data, destination, write enable, valid) to the WB stage.

Parameters:
- DATA_W, 32, width of ALU result, store data and memory data
- TIMEOUT_CYCLES, 255, WAIT-state cycles without ack before abort (only used with MEM_TIMEOUT_EN)

Ports:
- clock  in  1  single clock for all state
- reset  in  1  asynchronous, active-low reset
- valid_in  in  1  EX/MEM holds a real instruction (0 = bubble)
- alu_in  in  DATA_W  ALU result; used as memory byte address for loads/stores
- store_data_in  in  DATA_W  store data
- dst_in  in  5  destination register
- reg_write_in  in  1  instruction writes the register file
- mem_read_in  in  1  load
- mem_write_in  in  1  store
- stall_out  out  1  upstream must hold its outputs stable this cycle
- dmem_req  out  1  memory request, held until ack
- dmem_we  out  1  1 = store, 0 = load
- dmem_addr  out  DATA_W  request address
- dmem_wdata  out  DATA_W  store data
- dmem_ack  in  1  memory completes request this cycle
- dmem_rdata  in  DATA_W  load data, valid when dmem_ack = 1
- wb_valid  out  1  writeback bundle valid, one-cycle pulse per instruction
- wb_data  out  DATA_W  writeback data
- wb_dst  out  5  writeback register
- wb_reg_write  out  1  register file write enable
- mem_error  out  1  one-cycle pulse on access abort

Behaviour:
- Reset (reset = 0, asynchronous): state = IDLE; all outputs are 0, including dmem_req; counters and internal latches are 0. Any pending transaction is discarded with no writeback.
- State machine:
  - IDLE → WAIT: on valid_in & (mem_read_in | mem_write_in).
  - WAIT → IDLE: on dmem_ack (or on timeout, see Optional Feature).
- Memory op:
  - If mem_read_in and mem_write_in are both set, the instruction is treated as a store.
- IDLE, non-memory instruction (valid_in = 1, no mem bits):
  - Next edge: wb_valid = 1, wb_data = alu_in, wb_dst = dst_in, wb_reg_write = reg_write_in.
  - Latency: 1 cycle. stall_out = 0.
- IDLE, bubble (valid_in = 0):
  - Next edge: wb_valid = 0, wb_reg_write = 0.
- IDLE, memory instruction:
  - stall_out = 1 (combinational).
  - Next edge: latch alu_in, store_data_in, dst_in, reg_write_in and op type; set dmem_req = 1, dmem_we = op is store, dmem_addr and dmem_wdata from the latches. wb_valid = 0 for that cycle.
- WAIT:
  - Inputs are ignored.
  - dmem_req, dmem_we, dmem_addr and dmem_wdata are held stable until the ack cycle.
  - stall_out = ~dmem_ack, so upstream advances on the ack edge.
- Ack edge:
  - dmem_req = 0, state = IDLE, wb_valid = 1, wb_dst = latched dst.
  - Load: wb_data = dmem_rdata, wb_reg_write = latched reg_write.
  - Store: wb_data = latched address, wb_reg_write = 0.
- dmem_ack outside WAIT is ignored.
- Minimum memory latency: 2 cycles from instruction presentation to wb_valid (ack in the first WAIT cycle).
- No back-to-back memory pipelining. The next instruction is sampled only in IDLE.
- Throughput: 1 instruction/cycle for non-memory ops.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter clears on WAIT entry and increments each WAIT cycle without ack.
  - When the count reaches TIMEOUT_CYCLES - 1 with no ack, the next edge aborts: dmem_req = 0, state = IDLE, mem_error = 1 for one cycle, wb_valid = 1, wb_reg_write = 0, stall_out = 0 in the abort cycle.
  - An ack in the same cycle as the timeout wins: normal completion, no error.
- Undefined:
  - WAIT persists indefinitely until ack.
  - The mem_error port exists and is tied to 0; the counter is not present.

Test Plan:
- Reset asserted mid-WAIT (dmem_req = 1) → dmem_req, wb_valid and stall_out go to 0 immediately, without a clock edge; after release, a non-memory op with alu_in = 0x10, dst = 3 → next cycle wb_valid = 1, wb_data = 0x10, wb_dst = 3.
- Back-to-back ALU ops with alu_in = 1, 2, 3 → wb_data = 1, 2, 3 on consecutive cycles; stall_out stays 0.
- Load with alu_in = 0x100, dst = 7; ack after 3 WAIT cycles with rdata = 0xDEADBEEF → dmem_addr = 0x100 and dmem_we = 0, held for 3 cycles; stall_out high for 4 cycles total; then wb_data = 0xDEADBEEF, wb_dst = 7, wb_reg_write = 1.
- Store with address 0x20, data 0x55 and reg_write_in = 1; immediate ack → dmem_we = 1, dmem_wdata = 0x55; wb_valid = 1 with wb_reg_write = 0. A spurious ack later in IDLE has no effect.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES = 4, a load with no ack → abort after 4 WAIT cycles with mem_error pulsing for 1 cycle and wb_reg_write = 0. A repeat run with ack on the 4th cycle → normal writeback, mem_error = 0.
- Bubble (valid_in = 0) presented with mem_read_in = 1 → no dmem_req and wb_valid = 0.
